// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue: FSM encodings and default bus widths.
package if_fetch_queue_pkg;

    localparam logic [0:0] IfStCeOff = 1'b0;
    localparam logic [0:0] IfStRun   = 1'b1;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO with first-word-fall-through head, synchronous flush and occupancy count.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    // Pointers carry one extra bit so equal indices distinguish full from empty.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign head_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with prefetch queue and branch redirect.
// Optional IF_PERF_CNT_EN adds fetch/drop performance counters.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = InstAddrBus,
    parameter int                DATA_W   = InstBus,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [ADDR_W-1:0]      rom_addr_o,
    input  logic [DATA_W-1:0]      rom_data_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [ADDR_W-1:0]      id_pc_o,
    output logic [DATA_W-1:0]      id_inst_o,
    input  logic                   redirect_i,
    input  logic [ADDR_W-1:0]      redirect_pc_i,
    output logic [$clog2(DEPTH):0] fq_count_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]            perf_fetch_o,
    output logic [31:0]            perf_drop_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    logic [0:0]             state_reg;
    logic [ADDR_W-1:0]      pc_reg;
    logic [ADDR_W-1:0]      pc_next;
    logic [ADDR_W-1:0]      inflight_pc_reg;
    logic                   inflight_reg;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   empty;
    logic [CW-1:0]          count;
    logic [CW:0]            occupancy;
    logic [ADDR_W+DATA_W-1:0] head;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Every in-flight word already owns a queue slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_reg};
    assign issue     = (state_reg == IfStRun) && !redirect_i && (occupancy < DEPTH_V);

    always_comb begin
        pc_next = pc_reg;
        if (redirect_i) begin
            pc_next = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end else if (issue) begin
            pc_next = pc_reg + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IfStCeOff;
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg    <= IfStRun;
            pc_reg       <= pc_next;
            inflight_reg <= issue;
            if (issue) inflight_pc_reg <= pc_reg;
        end
    end

    assign push = inflight_reg && !redirect_i;
    assign pop  = id_valid_o && id_ready_i;

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({inflight_pc_reg, rom_data_i}),
        .pop       (pop),
        .flush     (redirect_i),
        .head_data (head),
        .count     (count),
        .empty     (empty)
    );

    assign rom_ce_o   = issue;
    assign rom_addr_o = pc_reg;
    assign id_valid_o = !empty && !redirect_i;
    assign id_pc_o    = id_valid_o ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign id_inst_o  = id_valid_o ? head[DATA_W-1:0] : '0;
    assign fq_count_o = count;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_reg;
    logic [31:0] perf_drop_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_reg <= '0;
            perf_drop_reg  <= '0;
        end else begin
            if (issue) perf_fetch_reg <= perf_fetch_reg + 32'd1;
            if (inflight_reg && redirect_i) perf_drop_reg <= perf_drop_reg + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_reg;
    assign perf_drop_o  = perf_drop_reg;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: queue-based reference model plus a wrap-around RESET_PC instance.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef IF_PERF_CNT_EN
    localparam int VW = 101 + 64;
`else
    localparam int VW = 101;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [CW-1:0] fq_count_o;

    logic        w_rst = 1'b0;
    logic        w_ce;
    logic [31:0] w_addr;
    logic [31:0] w_data = '0;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_inst;
    logic [CW-1:0] w_cnt;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o, perf_drop_o, w_perf_fetch, w_perf_drop;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .fq_count_o(fq_count_o)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch_o), .perf_drop_o(perf_drop_o)
`endif
    );

    if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(w_rst), .rom_ce_o(w_ce), .rom_addr_o(w_addr),
        .rom_data_i(w_data), .id_valid_o(w_valid), .id_ready_i(1'b1),
        .id_pc_o(w_pc), .id_inst_o(w_inst), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .fq_count_o(w_cnt)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_o(w_perf_fetch), .perf_drop_o(w_perf_drop)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      m_q[$];
    bit          m_run;
    bit          m_inflight;
    logic [31:0] m_pc, m_ipc, m_fetch, m_drop;
    logic [31:0] deliv_q[$];
    bit          last_ce;
    logic [31:0] last_addr;
    logic [VW-1:0] exp_all, obs_all, rst_vec;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [VW-1:0] pack_obs();
`ifdef IF_PERF_CNT_EN
        return {rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fq_count_o, perf_fetch_o, perf_drop_o};
`else
        return {rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, fq_count_o};
`endif
    endfunction

    // One clock of stimulus; leaves observed and model-predicted outputs in obs_all/exp_all.
    task automatic step(input bit ready, input bit redir, input logic [31:0] rpc);
        bit     ce, valid;
        entry_t hd, e;
        id_ready_i    = ready;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        rom_data_i    = last_ce ? rom_f(last_addr) : $urandom;
        #1;
        ce    = m_run && !redir && ((m_q.size() + int'(m_inflight)) < DEPTH);
        valid = (m_q.size() != 0) && !redir;
        hd    = valid ? m_q[0] : '0;
`ifdef IF_PERF_CNT_EN
        exp_all = {ce, m_pc, valid, hd.pc, hd.inst, 3'(m_q.size()), m_fetch, m_drop};
`else
        exp_all = {ce, m_pc, valid, hd.pc, hd.inst, 3'(m_q.size())};
`endif
        obs_all   = pack_obs();
        last_ce   = rom_ce_o;
        last_addr = rom_addr_o;
        if (redir) begin
            if (m_inflight) m_drop = m_drop + 1;
            m_q.delete();
        end else begin
            if (valid && ready) begin
                deliv_q.push_back(hd.pc);
                void'(m_q.pop_front());
            end
            if (m_inflight) begin
                e.pc = m_ipc; e.inst = rom_data_i;
                m_q.push_back(e);
            end
        end
        if (ce) begin
            m_fetch = m_fetch + 1;
            m_ipc   = m_pc;
            m_pc    = m_pc + 32'd4;
        end
        if (redir) m_pc = {rpc[31:2], 2'b00};
        m_inflight = ce;
        m_run      = 1'b1;
        @(negedge clk);
        cyc++;
    endtask

    // Asserts reset between edges, samples outputs 1 time unit later, releases at the next falling edge.
    task automatic do_reset();
        redirect_i = 1'b0;
        rst = 1'b0;
        #1;
        obs_all = pack_obs();
        m_q.delete();
        m_run = 0; m_inflight = 0; m_pc = 32'h0; m_ipc = 32'h0;
        m_fetch = 0; m_drop = 0; last_ce = 0; last_addr = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs_all !== rst_vec) begin
            miscompares++;
            $display("FAIL reset got=%h exp=%h", obs_all, rst_vec);
        end
    endtask

    task automatic test_stream();
        deliv_q.delete();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 32'h0);
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
            end
        end
        vectors++;
        if (deliv_q.size() < 3 || deliv_q[0] !== 32'h0 || deliv_q[1] !== 32'h4 || deliv_q[2] !== 32'h8) begin
            miscompares++;
            $display("FAIL stream_order got_n=%0d first=%h exp=00000000", deliv_q.size(),
                     deliv_q.size() > 0 ? deliv_q[0] : 32'hx);
        end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 20; i++) begin
            step(i >= 10, 1'b0, 32'h0);
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
            end
            if (i == 9) begin
                vectors++;
                if (fq_count_o !== 3'(DEPTH) || rom_ce_o !== 1'b0) begin
                    miscompares++;
                    $display("FAIL backpressure_full count=%0d ce=%b exp count=4 ce=0", fq_count_o, rom_ce_o);
                end
            end
        end
    endtask

    task automatic test_redirect();
        int guard = 0;
        while (!(m_q.size() == 3 && m_inflight) && guard < 20) begin
            step(1'b0, 1'b0, 32'h0);
            guard++;
        end
        vectors++;
        if (guard >= 20) begin
            miscompares++;
            $display("FAIL redirect_setup timeout q=%0d", m_q.size());
        end
        deliv_q.delete();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, i == 0, 32'h0000_0103);
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL redirect cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
            end
        end
        vectors++;
        if (deliv_q.size() == 0 || deliv_q[0] !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL redirect_first got=%h exp=00000100", deliv_q.size() > 0 ? deliv_q[0] : 32'hx);
        end
    endtask

    task automatic test_double_redirect();
        deliv_q.delete();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, i < 2, (i == 0) ? 32'h40 : 32'h80);
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL double_redirect cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
            end
        end
        vectors++;
        if (deliv_q.size() == 0 || deliv_q[0] !== 32'h80) begin
            miscompares++;
            $display("FAIL double_redirect_first got=%h exp=00000080", deliv_q.size() > 0 ? deliv_q[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        step(1'b1, 1'b1, 32'h200);
        while (m_q.size() != 2 && guard < 10) begin
            step(1'b0, 1'b0, 32'h0);
            guard++;
        end
        vectors++;
        if (guard >= 10) begin
            miscompares++;
            $display("FAIL mid_reset_setup timeout q=%0d", m_q.size());
        end
        do_reset();
        vectors++;
        if (obs_all !== rst_vec) begin
            miscompares++;
            $display("FAIL mid_reset got=%h exp=%h", obs_all, rst_vec);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 32'h0);
            vectors++;
            if (obs_all !== exp_all) begin
                miscompares++;
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc[3];
        logic [31:0] got_q[$];
        bit          wl_ce = 0;
        logic [31:0] wl_addr = '0;
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        w_rst = 1'b1; #1; w_rst = 1'b0; #1;
        vectors++;
        if (w_addr !== 32'hFFFF_FFF8 || w_ce !== 1'b0 || w_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_reset addr=%h ce=%b valid=%b exp addr=fffffff8 ce=0 valid=0", w_addr, w_ce, w_valid);
        end
        @(negedge clk);
        w_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w_data = wl_ce ? rom_f(wl_addr) : 32'h0;
            #1;
            wl_ce = w_ce; wl_addr = w_addr;
            if (w_valid) begin
                got_q.push_back(w_pc);
                vectors++;
                if (w_inst !== rom_f(w_pc)) begin
                    miscompares++;
                    $display("FAIL wrap_inst pc=%h got=%h exp=%h", w_pc, w_inst, rom_f(w_pc));
                end
            end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (got_q.size() <= k || got_q[k] !== exp_pc[k]) begin
                miscompares++;
                $display("FAIL wrap_pc%0d got=%h exp=%h", k, got_q.size() > k ? got_q[k] : 32'hx, exp_pc[k]);
            end
        end
    endtask

    initial begin
        rst_vec = '0;
        rst_vec[VW-2 -: 32] = 32'h0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_double_redirect();
        test_random();
        test_mid_reset();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
